vram_arbiter: RTL and testbench

- Shares the single-port video RAM between the text-mode pixel generator and the CPU bus.
- Pixel reads own the TEXT_FETCH and GLYPH_FETCH sub-pixel slots of every visible pixel. The CPU gets the WAIT and DRAW slots, plus every slot during blanking or while video is disabled.
- Buffers one CPU transaction and returns read data with a one-cycle ack.
- Also holds the pixel read data stable through the DRAW slot.

---
 rtl/vram_arbiter.sv | 155 +++++++++++++++
 tb/tb_vram_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between the text-mode pixel
// generator and the CPU bus. Pixel reads own the TEXT_FETCH and GLYPH_FETCH
// slots of visible pixels. Every other cycle belongs to the CPU, whose single
// buffered transaction is issued on the first CPU-owned slot and acknowledged
// with a one-cycle pulse.
//
// Ports:
//   clk, reset            clock (4 clocks per pixel), async active-high reset
//   enable                video enable; 0 hands every slot to the CPU
//   pixel_counter         current pixel from VGA timing
//   line_counter          current line from VGA timing
//   pixel_state           sub-pixel slot: 0 TEXT_FETCH, 1 GLYPH_FETCH, 2 WAIT, 3 DRAW
//   pg_addr / pg_data     pixel generator read address / read data
//   cpu_req .. cpu_wdata  CPU request (held until cpu_ack), we, address, data
//   cpu_ack / cpu_rdata   one-cycle completion pulse / read data (held)
//   cpu_busy              transaction buffered or in flight
//   mem_*                 VRAM port (synchronous read, 1-cycle latency)
module vram_arbiter #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [9:0]            pixel_counter,
  input  logic [8:0]            line_counter,
  input  logic [1:0]            pixel_state,
  input  logic [ADDR_WIDTH-1:0] pg_addr,
  output logic [DATA_WIDTH-1:0] pg_data,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ISSUED  = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   buf_addr_q, buf_addr_d;
  logic                    buf_we_q, buf_we_d;
  logic [DATA_WIDTH-1:0]   buf_wdata_q, buf_wdata_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                    cpu_busy_q, cpu_busy_d;
  logic [DATA_WIDTH-1:0]   pg_hold_q, pg_hold_d;
  logic                    pix_rd_q, pix_rd_d;

  logic active_c;
  logic pix_slot_c;
  logic cpu_issue_c;

  // Slot ownership follows the counters every cycle, no hysteresis.
  assign active_c    = enable
                     && (32'(pixel_counter) < H_VISIBLE)
                     && (32'(line_counter)  < V_VISIBLE);
  assign pix_slot_c  = active_c && ((pixel_state == 2'd0) || (pixel_state == 2'd1));
  assign cpu_issue_c = (state_q == ST_PENDING) && !pix_slot_c;

  // VRAM port mux: the buffered CPU access only reaches memory on a CPU slot,
  // so a CPU write can never coincide with a pixel read.
  always_comb begin
    mem_addr  = pg_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (cpu_issue_c) begin
      mem_addr  = buf_addr_q;
      mem_we    = buf_we_q;
      mem_wdata = buf_wdata_q;
    end
  end

  // Pixel read data is live the cycle after a pixel slot, otherwise the last
  // pixel word is replayed so the glyph stays stable through DRAW.
  assign pg_data   = pix_rd_q ? mem_rdata : pg_hold_q;
  assign pix_rd_d  = pix_slot_c;
  assign pg_hold_d = pix_rd_q ? mem_rdata : pg_hold_q;

  // CPU transaction sequencing: capture, wait for a CPU slot, collect data, ack.
  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    buf_we_d    = buf_we_q;
    buf_wdata_d = buf_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        // The ack guard keeps a still-asserted request from being taken twice.
        if (cpu_req && !cpu_ack_q) begin
          buf_addr_d  = cpu_addr;
          buf_we_d    = cpu_we;
          buf_wdata_d = cpu_wdata;
          state_d     = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (cpu_issue_c) state_d = ST_ISSUED;
      end
      ST_ISSUED: begin
        if (!buf_we_q) cpu_rdata_d = mem_rdata;
        cpu_ack_d = 1'b1;
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cpu_busy_d = (state_d != ST_IDLE);
  end

  // All state; reset drops any buffered request without acking or writing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      buf_addr_q  <= '0;
      buf_we_q    <= 1'b0;
      buf_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_busy_q  <= 1'b0;
      pg_hold_q   <= '0;
      pix_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_we_q    <= buf_we_d;
      buf_wdata_q <= buf_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_busy_q  <= cpu_busy_d;
      pg_hold_q   <= pg_hold_d;
      pix_rd_q    <= pix_rd_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_busy  = cpu_busy_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: drives VGA-style counters and CPU transactions into
// vram_arbiter, models the VRAM, and checks every cycle against a slot-level
// reference model plus a scoreboard of expected CPU read data.
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int unsigned AW      = 15;
  localparam int unsigned DW      = 16;
  localparam int unsigned H_VIS   = 640;
  localparam int unsigned V_VIS   = 480;
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_TOTAL = 525;
  localparam logic [AW-1:0] TEXT_A  = 15'h0A00;
  localparam logic [AW-1:0] GLYPH_A = 15'h6100;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [9:0]    pixel_counter;
  logic [8:0]    line_counter;
  logic [1:0]    pixel_state;
  logic [AW-1:0] pg_addr;
  logic [DW-1:0] pg_data;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_counter(pixel_counter), .line_counter(line_counter), .pixel_state(pixel_state),
    .pg_addr(pg_addr), .pg_data(pg_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- VRAM model (synchronous read-first BRAM + backdoor) ----
  bit   [DW-1:0] vram   [32768];
  bit            vvalid [32768];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 16'(32'(a) * 32'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
    return vvalid[a] ? vram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    mem_rdata <= peek(mem_addr);
    if (bd_we) begin
      vram[bd_addr]   <= bd_data;
      vvalid[bd_addr] <= 1'b1;
    end else if (mem_we) begin
      vram[mem_addr]   <= mem_wdata;
      vvalid[mem_addr] <= 1'b1;
    end
  end

  // ---------------- checking bookkeeping ------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  // CPU-visible memory contents, advanced in request order.
  logic [DW-1:0] cpu_ref [int];
  logic [DW-1:0] last_rd;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return cpu_ref.exists(int'(a)) ? cpu_ref[int'(a)] : init_val(a);
  endfunction

  // ---------------- monitor: slot-level reference model ---------------------
  int            mcyc = 0;
  bit            m_inflight, m_waiting;
  int            m_ack_cyc;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            prev_pix;
  logic [DW-1:0] pix_next, hold;

  initial begin : monitor
    bit            pix, exp_ack, issue;
    logic [DW-1:0] exp_pg;
    exp_t          e;
    m_inflight = 0; m_waiting = 0; m_ack_cyc = -1; prev_pix = 0; hold = '0; pix_next = '0;
    m_we = 0; m_addr = '0; m_wdata = '0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (reset) begin
        m_inflight = 0; m_waiting = 0; m_ack_cyc = -1; prev_pix = 0; hold = '0;
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_busy", 32'(cpu_busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_pg_data", 32'(pg_data), 32'd0);
      end else begin
        pix = enable && (32'(pixel_counter) < H_VIS) && (32'(line_counter) < V_VIS)
              && (pixel_state < 2'd2);
        // pixel data: the word read in a pixel slot appears next cycle, then is replayed
        exp_pg = prev_pix ? pix_next : hold;
        check("pg_data", 32'(pg_data), 32'(exp_pg));
        if (prev_pix) hold = pix_next;
        prev_pix = pix;
        if (pix) begin
          pix_next = peek(pg_addr);
          check("pix_mem_addr", 32'(mem_addr), 32'(pg_addr));
        end
        // CPU side
        exp_ack = m_inflight && (mcyc == m_ack_cyc);
        check("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
        check("cpu_busy", 32'(cpu_busy), 32'(m_inflight));
        issue = m_waiting && !pix;
        check("mem_we", 32'(mem_we), 32'(issue && m_we));
        if (issue) begin
          check("issue_addr", 32'(mem_addr), 32'(m_addr));
          if (m_we) check("issue_wdata", 32'(mem_wdata), 32'(m_wdata));
          m_ack_cyc = mcyc + 2;
          m_waiting = 0;
        end
        if (cpu_ack === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_ack: got an ack with nothing outstanding, required no ack at %0t", $time);
          end else begin
            e = sb.pop_front();
            check("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
          end
        end
        if (exp_ack) m_inflight = 0;
        else if (!m_inflight && cpu_req) begin
          m_inflight = 1; m_waiting = 1;
          m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
        end
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  bit            vid_run, pg_fixed;

  task automatic upd_pg();
    int t;
    t = int'(line_counter) * 80 + int'(pixel_counter);
    if (pg_fixed) pg_addr = (pixel_state == 2'd0) ? TEXT_A : GLYPH_A;
    else          pg_addr = (pixel_state == 2'd0) ? 15'(t) : 15'(24576 + t * 3);
  endtask

  task automatic set_video(input logic [9:0] pc, input logic [8:0] lc, input logic [1:0] ps);
    pixel_counter = pc; line_counter = lc; pixel_state = ps;
    upd_pg();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (vid_run) begin
      if (pixel_state == 2'd3) begin
        pixel_state = 2'd0;
        if (32'(pixel_counter) == H_TOTAL - 1) begin
          pixel_counter = 10'd0;
          line_counter  = (32'(line_counter) == V_TOTAL - 1) ? 9'd0 : line_counter + 9'd1;
        end else pixel_counter = pixel_counter + 10'd1;
      end else pixel_state = pixel_state + 2'd1;
    end
    upd_pg();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    cpu_ref[int'(a)] = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic start_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    e.we = we; e.addr = a;
    if (we) begin
      e.rdata = last_rd;
      cpu_ref[int'(a)] = d;
    end else begin
      e.rdata = ref_rd(a);
      last_rd = e.rdata;
    end
    sb.push_back(e);
  endtask

  task automatic cpu_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit hold_req, output int lat);
    start_req(we, a, d);
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (cpu_ack === 1'b1) break;
    end
    if (cpu_ack !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_timeout: no cpu_ack after %0d cycles, required an ack", lat);
    end
    if (!hold_req) cpu_req = 1'b0;
  endtask

  initial begin : stim
    int lat, gap, lo, exp_lat;
    bit held, hold_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;

    reset = 1'b1; enable = 1'b0; vid_run = 0; pg_fixed = 0;
    set_video(10'd700, 9'd0, 2'd0);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; last_rd = '0;
    idle(2);
    bd_write(15'h0100, 16'hBEEF);
    bd_write(TEXT_A,   16'h0041);
    bd_write(GLYPH_A,  16'h3C66);
    reset = 1'b0;
    idle(2);

    // Video disabled: read of 0x0100, minimum latency.
    cpu_txn(1'b0, 15'h0100, 16'h0, 1'b0, lat);
    check("lat_disabled", 32'(lat), 32'd3);
    check("rdata_beef", 32'(cpu_rdata), 32'hBEEF);
    idle(4);
    check("rdata_held", 32'(cpu_rdata), 32'hBEEF);

    // Blanking: write then read with the request held across the ack.
    enable = 1'b1; set_video(10'd700, 9'd100, 2'd0);
    cpu_txn(1'b1, 15'h2000, 16'h1234, 1'b1, lat);
    check("lat_blank_wr", 32'(lat), 32'd3);
    cpu_txn(1'b0, 15'h2000, 16'h0, 1'b0, lat);
    check("lat_blank_rd_b2b", 32'(lat), 32'd4);
    check("readback_1234", 32'(cpu_rdata), 32'h1234);
    idle(3);

    // Active pixel (10,10): PENDING begins at TEXT_FETCH, worst-case latency.
    vid_run = 1;
    set_video(10'd10, 9'd10, 2'd3);
    cpu_txn(1'b0, 15'h0100, 16'h0, 1'b0, lat);
    check("lat_text_fetch", 32'(lat), 32'd5);
    idle(3);

    // Pixel data path with a CPU write landing in WAIT.
    pg_fixed = 1;
    set_video(10'd20, 9'd20, 2'd3);
    start_req(1'b1, 15'h0300, 16'h7777);
    step();                       // TEXT_FETCH
    step();                       // GLYPH_FETCH
    @(negedge clk); check("pg_char_glyph_fetch", 32'(pg_data), 32'h0041);
    step();                       // WAIT, write issued here
    @(negedge clk); check("pg_glyph_wait", 32'(pg_data), 32'h3C66);
    check("wait_write_we", 32'(mem_we), 32'd1);
    step();                       // DRAW
    @(negedge clk); check("pg_glyph_draw", 32'(pg_data), 32'h3C66);
    step();
    check("ack_after_wait", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    pg_fixed = 0;
    idle(3);

    // Line 479 -> 480 while a request waits at TEXT_FETCH.
    vid_run = 0;
    set_video(10'd5, 9'd479, 2'd3);
    start_req(1'b0, 15'h2000, 16'h0);
    step(); set_video(10'd5, 9'd479, 2'd0);
    @(negedge clk); check("held_in_pix_slot", 32'(mem_addr), 32'(pg_addr));
    step(); set_video(10'd5, 9'd480, 2'd0);
    @(negedge clk); check("issue_at_line480", 32'(mem_addr), 32'h2000);
    step();
    step();
    check("ack_line480", 32'(cpu_ack), 32'd1);
    check("rdata_line480", 32'(cpu_rdata), 32'h1234);
    cpu_req = 1'b0;
    idle(3);

    // Reset while a write is pending on a CPU slot.
    enable = 1'b0; set_video(10'd700, 9'd0, 2'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0555; cpu_wdata = 16'hDEAD;
    step();
    check("pre_rst_mem_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_mem_we", 32'(mem_we), 32'd0);
    check("async_rst_busy", 32'(cpu_busy), 32'd0);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    reset = 1'b0; last_rd = '0;
    idle(3);
    check("rst_no_write", 32'(peek(15'h0555)), 32'(init_val(15'h0555)));
    check("rst_rdata_cleared", 32'(cpu_rdata), 32'd0);

    // Randomised traffic across the visible/blank and line-480 edges.
    vid_run = 1; enable = 1'b1;
    set_video(10'd600, 9'd479, 2'd0);
    held = 0;
    for (int i = 0; i < 300; i++) begin
      gap = held ? 0 : int'($urandom_range(0, 3));
      idle(gap);
      lo = (gap == 0 && i > 0) ? 4 : 3;
      enable  = ($urandom_range(0, 7) != 0);
      we_r    = 1'($urandom_range(0, 1));
      addr_r  = 15'h1000 + 15'($urandom_range(0, 31));
      wdata_r = 16'($urandom);
      hold_r  = ($urandom_range(0, 3) == 0);
      cpu_txn(we_r, addr_r, wdata_r, hold_r, lat);
      exp_lat = (lat < lo) ? lo : ((lat > lo + 2) ? lo + 2 : lat);
      check("lat_range", 32'(lat), 32'(exp_lat));
      held = hold_r;
    end
    cpu_req = 1'b0;
    idle(6);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
